// File: rtl/z80_int_ctrl.sv
// Z80 IM2 interrupt controller: four prioritised sources, I/O-mapped registers,
// and vector supply during the interrupt-acknowledge cycle, all in the CLK_24MHz domain.
module z80_int_ctrl #(
   parameter logic [7:0]  MASK_PORT = 8'h30,
   parameter logic [7:0]  STAT_PORT = 8'h31,
   parameter logic [7:0]  VEC_PORT  = 8'h32,
   parameter logic [7:0]  TMR_PORT  = 8'h33,
   parameter int unsigned TICK_DIV  = 24000
) (
   input  logic       CLK_24MHz,
   input  logic       RST,
   input  logic       IORQ,
   input  logic       M1,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] A_L,
   input  logic [7:0] D_IN,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   input  logic       U_INT,
   input  logic [1:0] EXT_INT,
   output logic       INT
);

   localparam int unsigned     PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [3:0]      EDGE_SRC = 4'b0101;

   logic [1:0]       r_iorq_s, r_m1_s, r_wr_s, r_uint_s, r_ext0_s, r_ext1_s;
   logic             r_iowr_prev, r_inta_prev, r_ext0_prev;
   logic             r_wr_pend;
   logic [7:0]       r_wr_addr, r_wr_data;
   logic [3:0]       r_mask, r_pend;
   logic [7:0]       r_vec, r_period;
   logic [PRE_W-1:0] r_pre;
   logic [7:0]       r_tcnt;
   logic [7:0]       r_ack_vec;
   logic             r_ack_valid;
   logic             r_int;

   logic       w_iorq_s, w_m1_s, w_wr_s, w_uint_s, w_ext0_s, w_ext1_s;
   logic       w_iowr_s, w_wr_fall, w_inta_s, w_inta_fall, w_ext0_fall;
   logic       w_inta_raw, w_rd_raw, w_rd_hit;
   logic       w_tmr_wr, w_tick, w_wrap;
   logic [1:0] w_win;
   logic [3:0] w_req, w_w1c, w_ack_clr, w_set, w_edge_nxt;
   logic [7:0] w_rd_data;

   assign w_iorq_s    = r_iorq_s[1];
   assign w_m1_s      = r_m1_s[1];
   assign w_wr_s      = r_wr_s[1];
   assign w_uint_s    = r_uint_s[1];
   assign w_ext0_s    = r_ext0_s[1];
   assign w_ext1_s    = r_ext1_s[1];
   assign w_iowr_s    = w_iorq_s | w_wr_s;
   assign w_wr_fall   = r_iowr_prev & ~w_iowr_s & w_m1_s;
   assign w_inta_s    = ~w_m1_s & ~w_iorq_s;
   assign w_inta_fall = w_inta_s & ~r_inta_prev;
   assign w_ext0_fall = r_ext0_prev & ~w_ext0_s;

   // 2-flop synchronisers, reset to the inactive level of each line
   always_ff @(posedge CLK_24MHz or posedge RST) begin
      if (RST) begin
         r_iorq_s    <= 2'b11;
         r_m1_s      <= 2'b11;
         r_wr_s      <= 2'b11;
         r_uint_s    <= 2'b00;
         r_ext0_s    <= 2'b11;
         r_ext1_s    <= 2'b11;
         r_iowr_prev <= 1'b1;
         r_inta_prev <= 1'b0;
         r_ext0_prev <= 1'b1;
      end else begin
         r_iorq_s    <= {r_iorq_s[0], IORQ};
         r_m1_s      <= {r_m1_s[0], M1};
         r_wr_s      <= {r_wr_s[0], WR};
         r_uint_s    <= {r_uint_s[0], U_INT};
         r_ext0_s    <= {r_ext0_s[0], EXT_INT[0]};
         r_ext1_s    <= {r_ext1_s[0], EXT_INT[1]};
         r_iowr_prev <= w_iowr_s;
         r_inta_prev <= w_inta_s;
         r_ext0_prev <= w_ext0_s;
      end
   end

   // Capture the write cycle, apply register updates one cycle later
   always_ff @(posedge CLK_24MHz or posedge RST) begin
      if (RST) begin
         r_wr_pend <= 1'b0;
         r_wr_addr <= 8'h00;
         r_wr_data <= 8'h00;
         r_mask    <= 4'h0;
         r_vec     <= 8'h00;
         r_period  <= 8'h00;
      end else begin
         r_wr_pend <= w_wr_fall;
         if (w_wr_fall) begin
            r_wr_addr <= A_L;
            r_wr_data <= D_IN;
         end
         if (r_wr_pend) begin
            if (r_wr_addr == MASK_PORT) r_mask   <= r_wr_data[3:0];
            if (r_wr_addr == VEC_PORT)  r_vec    <= {r_wr_data[7:3], 3'b000};
            if (r_wr_addr == TMR_PORT)  r_period <= r_wr_data;
         end
      end
   end

   assign w_tmr_wr = r_wr_pend & (r_wr_addr == TMR_PORT);
   assign w_tick   = (r_period != 8'd0) & (r_pre == PRE_MAX);
   assign w_wrap   = w_tick & (r_tcnt == (r_period - 8'd1));

   always_ff @(posedge CLK_24MHz or posedge RST) begin
      if (RST) begin
         r_pre  <= '0;
         r_tcnt <= 8'd0;
      end else if (w_tmr_wr || (r_period == 8'd0)) begin
         r_pre  <= '0;
         r_tcnt <= 8'd0;
      end else if (w_tick) begin
         r_pre  <= '0;
         r_tcnt <= w_wrap ? 8'd0 : r_tcnt + 8'd1;
      end else begin
         r_pre  <= r_pre + PRE_W'(1);
      end
   end

   assign w_req = r_pend & r_mask;

   always_comb begin
      w_win = 2'd0;
      if      (w_req[0]) w_win = 2'd0;
      else if (w_req[1]) w_win = 2'd1;
      else if (w_req[2]) w_win = 2'd2;
      else if (w_req[3]) w_win = 2'd3;
   end

   // The acknowledged source is taken from the frozen vector, i.e. what the CPU was given
   assign w_w1c      = (r_wr_pend && (r_wr_addr == STAT_PORT)) ? (r_wr_data[3:0] & EDGE_SRC) : 4'h0;
   assign w_ack_clr  = (w_inta_fall && r_ack_valid) ? ((4'b0001 << r_ack_vec[2:1]) & EDGE_SRC) : 4'h0;
   assign w_set      = {1'b0, w_ext0_fall, 1'b0, w_wrap};
   assign w_edge_nxt = (r_pend & ~(w_w1c | w_ack_clr)) | w_set;

   always_ff @(posedge CLK_24MHz or posedge RST) begin
      if (RST) begin
         r_pend      <= 4'h0;
         r_int       <= 1'b1;
         r_ack_vec   <= 8'h00;
         r_ack_valid <= 1'b0;
      end else begin
         r_pend <= {~w_ext1_s, w_edge_nxt[2], w_uint_s, w_edge_nxt[0]};
         r_int  <= ~(|w_req);
         if (!w_inta_raw) begin
            r_ack_vec   <= r_vec | {5'd0, w_win, 1'b0};
            r_ack_valid <= |w_req;
         end
      end
   end

   assign w_inta_raw = ~M1 & ~IORQ;
   assign w_rd_raw   = ~IORQ & ~RD & M1;

   always_comb begin
      w_rd_data = 8'h00;
      w_rd_hit  = 1'b1;
      if      (A_L == MASK_PORT) w_rd_data = {4'h0, r_mask};
      else if (A_L == STAT_PORT) w_rd_data = {w_req, r_pend};
      else if (A_L == VEC_PORT)  w_rd_data = r_vec;
      else if (A_L == TMR_PORT)  w_rd_data = r_period;
      else                       w_rd_hit  = 1'b0;
   end

   // INTA wins the bus over a simultaneous I/O read
   assign D_OE  = ~RST & (w_inta_raw | (w_rd_raw & w_rd_hit));
   assign D_OUT = ~D_OE ? 8'h00 : (w_inta_raw ? r_ack_vec : w_rd_data);
   assign INT   = r_int;

endmodule

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
- Z80 IM2 interrupt controller for the CPLD, alongside the memory mapper and system register.
- Collects four sources: internal periodic timer, 16550 U_INT, and two external lines.
- Arbitrates the sources by fixed priority, drives the CPU INT line, and supplies the vector during the interrupt-acknowledge cycle.
- Exposes its registers as I/O ports and runs synchronously in the CLK_24MHz domain.

Parameters:
- MASK_PORT, 8'h30, interrupt mask register port.
- STAT_PORT, 8'h31, pending status read / write-1-to-clear port.
- VEC_PORT, 8'h32, vector base register port.
- TMR_PORT, 8'h33, timer period register port.
- TICK_DIV, 24000, CLK_24MHz cycles per timer tick (1 kHz).

Ports:
- CLK_24MHz  in  1  main clock.
- RST  in  1  asynchronous active-high reset.
- IORQ  in  1  Z80 IORQ, active low, asynchronous to CLK_24MHz.
- M1  in  1  Z80 M1, active low.
- RD  in  1  Z80 RD, active low.
- WR  in  1  Z80 WR, active low.
- A_L  in  8  CPU address bits 7:0.
- D_IN  in  8  CPU data bus, input side.
- D_OUT  out  8  data driven onto the bus.
- D_OE  out  1  D_OUT enable; the top level tri-states D with it.
- U_INT  in  1  16550 interrupt, active-high level.
- EXT_INT  in  2  external requests, active low. Bit 0 is edge-type, bit 1 is level-type.
- INT  out  1  Z80 INT, active low.

Behaviour:
- Reset (RST=1, async):
  - mask=8'h00 (all sources disabled), pending=0, vec_base=8'h00, period=0.
  - Prescaler and timer counters are 0.
  - INT=1, D_OE=0, D_OUT=0.
- Input synchronisers:
  - IORQ, M1, WR, U_INT and EXT_INT pass through 2-flop synchronisers.
  - Edge detection compares the synchronised value with the previous sample.
- Source bits, where a lower index means higher priority:
  - 0 = timer, edge-type.
  - 1 = U_INT, level-type.
  - 2 = EXT_INT[0] falling edge, edge-type.
  - 3 = EXT_INT[1] low, level-type.
- Edge-type pending bits:
  - Set on the event.
  - Cleared by acknowledge or by a W1C write.
  - If set and clear land in the same cycle, set wins.
- Level-type pending bits follow the synchronised level every cycle. Acknowledge and W1C have no effect on them.
- Timer:
  - The prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick on wrap.
  - With period=N, N≠0: the timer counter counts ticks 0..N-1 and sets pending[0] on wrap.
  - With period=0: the timer counter and prescaler are held at 0 and no events occur.
  - Writing TMR_PORT reloads both counters to 0.
- I/O write:
  - Detected on the synchronised falling edge of (IORQ|WR) with M1=1.
  - A_L and D_IN are captured on that cycle and the register update takes effect on the next cycle.
  - MASK_PORT writes mask[3:0]; bits 7:4 are ignored and read as 0.
  - STAT_PORT write: every 1 bit clears the matching edge-type pending bit.
  - VEC_PORT writes vec_base, and bits 2:0 are forced to 0.
  - TMR_PORT writes period.
- I/O read is combinational: D_OE = ~IORQ & ~RD & M1 & port-match.
  - MASK_PORT reads {4'h0, mask}.
  - STAT_PORT reads {masked pending[3:0], raw pending[3:0]}.
  - VEC_PORT reads vec_base.
  - TMR_PORT reads period.
- Arbitration:
  - req = pending & mask[3:0].
  - win = lowest set index of req.
  - INT is registered and equals ~(|req), with 1-cycle latency after req changes.
- Acknowledge cycle (IM2):
  - The INTA condition is M1=0 & IORQ=0.
  - A vector register ack_vec = vec_base | {win,1'b0} updates every cycle while INTA is inactive and freezes while INTA is active.
  - D_OE is asserted combinationally during INTA with D_OUT=ack_vec.
  - On the synchronised INTA falling edge, pending[win] is cleared if win is edge-type. Level-type bits stay pending until the device deasserts.
  - INTA with req=0 (spurious): D_OUT=vec_base, no pending bit changes.
- Read/INTA overlap: if INTA and an I/O read are true together, INTA has priority on D_OUT.
- Timer wrap during INTA: the new event sets pending[0] after the acknowledge clear is applied, so the event is not lost.
- Mid-operation reset: everything returns to reset values immediately; INT=1 and D_OE=0 asynchronously.

Test Plan:
- Reset: pulse RST during an active INTA -> D_OE=0 and INT=1 at once. Reads of 0x30/0x31/0x32/0x33 then return 00/00/00/00.
- Timer: TICK_DIV=4 in the bench, write 0x33=3 and 0x30=01, vec 0x32=A5 (reads back A0) -> INT falls 12 clocks + sync latency after the write. INTA drives D_OUT=A0 and INT returns to 1 within 4 clocks after INTA.
- Priority: U_INT=1 and EXT_INT[0] fall together, mask=0F, vec=40:
  - First INTA returns 42 and INT stays 0 while U_INT=1.
  - After U_INT=0, INTA returns 44.
  - After that acknowledge, INT=1.
- Mask/W1C: EXT_INT[0] edge with mask=00 -> INT=1 and 0x31 reads 04. Write 0x31=04 -> reads 00. Write 0x31=02 while U_INT=1 -> bit1 remains set.
- Simultaneous event: timer wrap in the same cycle as the INTA clear of pending[0] -> pending[0] remains 1 and a second INTA yields vector base|0.
- Spurious: INTA with mask=0, vec=80 -> D_OUT=80, D_OE=1, status unchanged.
